// File: rtl/etpu_pkg.sv
// etpu_pkg: shared Wishbone widths, initiator FSM encoding and command entry layout
package etpu_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SELW = 4;
  localparam int CMD_W = 1 + WB_SELW + WB_AW + WB_DW;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
  typedef struct packed {
    logic               we;
    logic [WB_SELW-1:0] sel;
    logic [WB_AW-1:0]   adr;
    logic [WB_DW-1:0]   dat;
  } cmd_t;
endpackage

// File: rtl/etpu_sync_fifo.sv
// etpu_sync_fifo: synchronous FIFO with wrap-bit pointers and combinational head read
module etpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/etpu_wb_initiator.sv
// etpu_wb_initiator: queued Wishbone classic initiator, one transaction and one response per command
module etpu_wb_initiator
  import etpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCS = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [WB_SELW-1:0] cmd_sel,
  input  logic [WB_AW-1:0]   cmd_adr,
  input  logic [WB_DW-1:0]   cmd_dat,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               busy,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic [WB_DW-1:0]   wbm_dat_i
);
  localparam int CW = $clog2(TIMEOUT_CYCS + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [CMD_W-1:0] head_raw;
  cmd_t head;
  logic full, empty, pop;
  assign head = cmd_t'(head_raw);
  assign pop = (state == IDLE) && !empty;
  assign cmd_ready = !full;
  assign busy = !empty || (state != IDLE);
  etpu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .push(cmd_valid), .pop(pop),
    .din({cmd_we, cmd_sel, cmd_adr, cmd_dat}), .dout(head_raw),
    .full(full), .empty(empty)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} <= head;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          cnt <= '0;
          state <= BUS;
        end
        BUS: begin
          cnt <= cnt + CW'(1);
          // ack is checked first so it wins over a coincident timeout
          if (wbm_ack_i || cnt == CW'(TIMEOUT_CYCS - 1)) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err <= !wbm_ack_i;
            rsp_dat <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
            state <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
